// File: rtl/alu_pkg.sv
// Shared opcode constants, state encoding and helpers for the ALU operation sequencer.
// The optional divide-by-zero trap is enabled by ALU_DIV0_TRAP_EN in the top module.
package alu_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_DIV = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_OR  = 3'b101;

    localparam int R15_ADDR = 15;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_READ     = 3'd1,
        ST_EXEC     = 3'd2,
        ST_WB       = 3'd3,
        ST_WB15     = 3'd4,
        ST_DONE_ILL = 3'd5
    } state_e;

    function automatic logic is_muldiv(input logic [2:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

    function automatic logic is_legal(input logic [2:0] op);
        return op <= OP_OR;
    endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Operation handshake between instruction decode (master) and the ALU sequencer (slave).
interface alu_op_sequencer_if #(
    parameter int AW = 4
);
    logic          op_valid;
    logic          op_ready;
    logic [2:0]    op_code;
    logic [AW-1:0] op_rd;
    logic [AW-1:0] op_rs;
    logic [AW-1:0] op_rt;

    modport master (
        output op_valid, op_code, op_rd, op_rs, op_rt,
        input  op_ready
    );

    modport slave (
        input  op_valid, op_code, op_rd, op_rs, op_rt,
        output op_ready
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// Multi-cycle sequencer: reads operands, drives the external ALU, writes r (and R15 for MUL/DIV).
// Define ALU_DIV0_TRAP_EN to trap DIV by zero before the ALU is issued (adds err_div0).
//
// state    | meaning
// IDLE     | op_ready high, waiting for a handshake
// READ     | register-file read of rs/rt into a_q/b_q
// EXEC     | ALU driven from a_q/b_q/op_q; 1 cycle, or MULDIV_CYCLES for MUL/DIV
// WB       | write r_q to rd; retires non-MUL/DIV ops
// WB15     | write r15_q to R15; retires MUL/DIV
// DONE_ILL | retire illegal opcode (or trapped DIV by zero) with no write
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int DW            = 16,
    parameter int AW            = 4,
    parameter int MULDIV_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rst,
    alu_op_sequencer_if.slave   op,
    output logic [AW-1:0]       rf_ra_addr,
    output logic [AW-1:0]       rf_rb_addr,
    input  logic [DW-1:0]       rf_ra_data,
    input  logic [DW-1:0]       rf_rb_data,
    output logic [DW-1:0]       alu_a,
    output logic [DW-1:0]       alu_b,
    output logic [2:0]          alu_sel,
    input  logic [DW-1:0]       alu_r,
    input  logic [DW-1:0]       alu_r15,
    input  logic                alu_ovf,
    output logic                rf_we,
    output logic [AW-1:0]       rf_waddr,
    output logic [DW-1:0]       rf_wdata,
    output logic                busy,
    output logic                done,
    output logic                status_ovf,
`ifdef ALU_DIV0_TRAP_EN
    output logic                err_div0,
`endif
    output logic                err_illegal
);

    localparam logic [2:0] S_IDLE     = ST_IDLE;
    localparam logic [2:0] S_READ     = ST_READ;
    localparam logic [2:0] S_EXEC     = ST_EXEC;
    localparam logic [2:0] S_WB       = ST_WB;
    localparam logic [2:0] S_WB15     = ST_WB15;
    localparam logic [2:0] S_DONE_ILL = ST_DONE_ILL;

    localparam int CW = (MULDIV_CYCLES > 1) ? $clog2(MULDIV_CYCLES) : 1;

    logic [2:0]    state_q, state_d;
    logic [2:0]    op_q;
    logic [AW-1:0] rd_q, rs_q, rt_q;
    logic [DW-1:0] a_q, b_q, r_q, r15_q;
    logic          ovf_q;
    logic          status_q;
    logic [CW-1:0] cnt_q;

`ifdef ALU_DIV0_TRAP_EN
    logic div0_q;
    logic div0_hit;

    // Checked on the live read data so the ALU is never issued a zero divisor.
    assign div0_hit = (state_q == S_READ) && (op_q == OP_DIV) && (rf_rb_data == '0);
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (op.op_valid)
                    state_d = is_legal(op.op_code) ? S_READ : S_DONE_ILL;
            end
            S_READ: begin
`ifdef ALU_DIV0_TRAP_EN
                state_d = div0_hit ? S_DONE_ILL : S_EXEC;
`else
                state_d = S_EXEC;
`endif
            end
            S_EXEC: begin
                if (cnt_q == '0)
                    state_d = S_WB;
            end
            S_WB:       state_d = is_muldiv(op_q) ? S_WB15 : S_IDLE;
            S_WB15:     state_d = S_IDLE;
            S_DONE_ILL: state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            rd_q     <= '0;
            rs_q     <= '0;
            rt_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            r_q      <= '0;
            r15_q    <= '0;
            ovf_q    <= 1'b0;
            status_q <= 1'b0;
            cnt_q    <= '0;
`ifdef ALU_DIV0_TRAP_EN
            div0_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;

            if ((state_q == S_IDLE) && op.op_valid) begin
                op_q <= op.op_code;
                rd_q <= op.op_rd;
                rs_q <= op.op_rs;
                rt_q <= op.op_rt;
`ifdef ALU_DIV0_TRAP_EN
                div0_q <= 1'b0;
`endif
            end

            if (state_q == S_READ) begin
                a_q   <= rf_ra_data;
                b_q   <= rf_rb_data;
                cnt_q <= is_muldiv(op_q) ? CW'(MULDIV_CYCLES - 1) : '0;
`ifdef ALU_DIV0_TRAP_EN
                div0_q <= div0_hit;
`endif
            end

            // Down-counter: results are captured on terminal count.
            if (state_q == S_EXEC) begin
                if (cnt_q == '0) begin
                    r_q   <= alu_r;
                    r15_q <= alu_r15;
                    ovf_q <= alu_ovf;
                end else begin
                    cnt_q <= cnt_q - CW'(1);
                end
            end

            if (done && (state_q != S_DONE_ILL))
                status_q <= ovf_q;
        end
    end

    always_comb begin
        op.op_ready = 1'b0;
        rf_ra_addr  = '0;
        rf_rb_addr  = '0;
        alu_a       = '0;
        alu_b       = '0;
        alu_sel     = '0;
        rf_we       = 1'b0;
        rf_waddr    = '0;
        rf_wdata    = '0;
        done        = 1'b0;
        err_illegal = 1'b0;
`ifdef ALU_DIV0_TRAP_EN
        err_div0    = 1'b0;
`endif
        case (state_q)
            S_IDLE: op.op_ready = 1'b1;
            S_READ: begin
                rf_ra_addr = rs_q;
                rf_rb_addr = rt_q;
            end
            S_EXEC: begin
                alu_a   = a_q;
                alu_b   = b_q;
                alu_sel = op_q;
            end
            S_WB: begin
                rf_we    = 1'b1;
                rf_waddr = rd_q;
                rf_wdata = r_q;
                done     = !is_muldiv(op_q);
            end
            S_WB15: begin
                rf_we    = 1'b1;
                rf_waddr = AW'(R15_ADDR);
                rf_wdata = r15_q;
                done     = 1'b1;
            end
            S_DONE_ILL: begin
                done = 1'b1;
`ifdef ALU_DIV0_TRAP_EN
                err_illegal = !div0_q;
                err_div0    = div0_q;
`else
                err_illegal = 1'b1;
`endif
            end
            default: ;
        endcase
    end

    assign busy       = (state_q != S_IDLE);
    assign status_ovf = status_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench: table vectors, reset/corner sequences and randomized ops against an op-level model.
module tb_alu_op_sequencer;
    import alu_pkg::*;

    localparam int DW = 16;
    localparam int AW = 4;
    localparam int M  = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_op_sequencer_if #(.AW(AW)) ifc ();

    logic [AW-1:0] rf_ra_addr, rf_rb_addr, rf_waddr;
    logic [DW-1:0] rf_ra_data, rf_rb_data, alu_a, alu_b, alu_r, alu_r15, rf_wdata;
    logic [2:0]    alu_sel;
    logic          alu_ovf, rf_we, busy, done, status_ovf, err_illegal;
`ifdef ALU_DIV0_TRAP_EN
    logic          err_div0;
`endif

    alu_op_sequencer #(.DW(DW), .AW(AW), .MULDIV_CYCLES(M)) dut (
        .clk(clk), .rst(rst), .op(ifc),
        .rf_ra_addr(rf_ra_addr), .rf_rb_addr(rf_rb_addr),
        .rf_ra_data(rf_ra_data), .rf_rb_data(rf_rb_data),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_r(alu_r), .alu_r15(alu_r15), .alu_ovf(alu_ovf),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .busy(busy), .done(done), .status_ovf(status_ovf),
`ifdef ALU_DIV0_TRAP_EN
        .err_div0(err_div0),
`endif
        .err_illegal(err_illegal)
    );

    // Behavioural 16-bit signed ALU, computed with plain integer arithmetic.
    function automatic void alu_fn(input logic [2:0] s, input logic [15:0] a, input logic [15:0] b,
                                   output logic [15:0] r, output logic [15:0] r15, output logic ovf);
        int sa, sb, res, rem;
        sa = int'($signed(a));
        sb = int'($signed(b));
        r = '0; r15 = '0; ovf = 1'b0;
        case (s)
            3'd0: begin res = sa + sb; r = res[15:0]; ovf = (res > 32767) || (res < -32768); end
            3'd1: begin res = sa - sb; r = res[15:0]; ovf = (res > 32767) || (res < -32768); end
            3'd2: begin res = sa * sb; r = res[15:0]; r15 = res[31:16]; end
            3'd3: begin
                if (sb == 0) begin r = 16'hFFFF; r15 = a; end
                else begin res = sa / sb; rem = sa % sb; r = res[15:0]; r15 = rem[15:0]; end
            end
            3'd4: r = a & b;
            3'd5: r = a | b;
            default: ;
        endcase
    endfunction

    always_comb alu_fn(alu_sel, alu_a, alu_b, alu_r, alu_r15, alu_ovf);

    // Register file with write log; preload port used only while the DUT is idle.
    logic [15:0] rf [16];
    logic        pl_we = 1'b0;
    logic [3:0]  pl_addr = '0;
    logic [15:0] pl_data = '0;
    int          wr_cnt = 0;
    int          done_cnt = 0;
    logic [3:0]  wl_a [64];
    logic [15:0] wl_d [64];

    assign rf_ra_data = rf[rf_ra_addr];
    assign rf_rb_data = rf[rf_rb_addr];

    always @(posedge clk) begin
        if (rf_we) begin
            rf[rf_waddr]       <= rf_wdata;
            wl_a[wr_cnt[5:0]]  <= rf_waddr;
            wl_d[wr_cnt[5:0]]  <= rf_wdata;
            wr_cnt             <= wr_cnt + 1;
        end else if (pl_we) begin
            rf[pl_addr] <= pl_data;
        end
        if (done) done_cnt <= done_cnt + 1;
    end

    logic [15:0] ref_rf [16];
    logic        ref_status;
    int          errors = 0;
    int          checks = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic set_reg(input logic [3:0] addr, input logic [15:0] data);
        pl_we = 1'b1; pl_addr = addr; pl_data = data;
        @(negedge clk);
        pl_we = 1'b0;
        ref_rf[addr] = data;
    endtask

    // Issue one op from a negedge, wait for done, then check retire timing, writes and status.
    task automatic run_check(input string tag, input logic [2:0] code,
                             input logic [3:0] rd, input logic [3:0] rs, input logic [3:0] rt,
                             input int exp_done, input int exp_nw,
                             input logic [3:0] a0, input logic [15:0] d0,
                             input logic [3:0] a1, input logic [15:0] d1,
                             input bit exp_ill, input bit exp_d0, input bit exp_ovf);
        int guard, ws, dc0, done_at;
        bit ill, dz;
        guard = 0;
        while (!ifc.op_ready && guard < 50) begin @(negedge clk); guard++; end
        chk($sformatf("%s.ready_before", tag), {31'd0, ifc.op_ready}, 32'd1);
        ws = wr_cnt; dc0 = done_cnt;
        ifc.op_valid = 1'b1; ifc.op_code = code; ifc.op_rd = rd; ifc.op_rs = rs; ifc.op_rt = rt;
        @(negedge clk);
        ifc.op_valid = 1'b0;
        done_at = -1; ill = 1'b0; dz = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            if (n > 1) @(negedge clk);
            if (done) begin
                done_at = n;
                ill = err_illegal;
`ifdef ALU_DIV0_TRAP_EN
                dz = err_div0;
`endif
                chk($sformatf("%s.ready_at_done", tag), {31'd0, ifc.op_ready}, 32'd0);
                break;
            end
        end
        chk($sformatf("%s.done_cycle", tag), done_at, exp_done);
        chk($sformatf("%s.err_illegal", tag), {31'd0, ill}, {31'd0, exp_ill});
        chk($sformatf("%s.err_div0", tag), {31'd0, dz}, {31'd0, exp_d0});
        @(negedge clk);
        chk($sformatf("%s.ready_after", tag), {31'd0, ifc.op_ready}, 32'd1);
        chk($sformatf("%s.status_ovf", tag), {31'd0, status_ovf}, {31'd0, exp_ovf});
        chk($sformatf("%s.n_writes", tag), wr_cnt - ws, exp_nw);
        chk($sformatf("%s.n_done", tag), done_cnt - dc0, 1);
        if (exp_nw >= 1 && wr_cnt - ws >= 1) begin
            chk($sformatf("%s.w0_addr", tag), {28'd0, wl_a[ws[5:0]]}, {28'd0, a0});
            chk($sformatf("%s.w0_data", tag), {16'd0, wl_d[ws[5:0]]}, {16'd0, d0});
        end
        if (exp_nw >= 2 && wr_cnt - ws >= 2) begin
            chk($sformatf("%s.w1_addr", tag), {28'd0, wl_a[6'(ws + 1)]}, {28'd0, a1});
            chk($sformatf("%s.w1_data", tag), {16'd0, wl_d[6'(ws + 1)]}, {16'd0, d1});
        end
    endtask

    // Op-level reference: derive expected retire cycle, writes and status from the register model.
    task automatic ref_op(input logic [2:0] code, input logic [3:0] rd, input logic [3:0] rs, input logic [3:0] rt);
        logic [15:0] a, b, r, r15;
        logic ovf;
        int ed, nw;
        bit ill, dz;
        a = ref_rf[rs]; b = ref_rf[rt];
        r = '0; r15 = '0; ovf = ref_status; ill = 1'b0; dz = 1'b0; nw = 0; ed = 1;
        if (code > 3'd5) begin
            ill = 1'b1;
        end
`ifdef ALU_DIV0_TRAP_EN
        else if (code == 3'd3 && b == 16'd0) begin
            dz = 1'b1; ed = 2;
        end
`endif
        else begin
            alu_fn(code, a, b, r, r15, ovf);
            nw = (code == 3'd2 || code == 3'd3) ? 2 : 1;
            ed = (nw == 2) ? 3 + M : 3;
        end
        run_check($sformatf("rnd_op%0d", code), code, rd, rs, rt, ed, nw, rd, r, 4'd15, r15, ill, dz, ovf);
        if (nw > 0) ref_rf[rd] = r;
        if (nw == 2) ref_rf[15] = r15;
        ref_status = ovf;
    endtask

    typedef struct {
        logic [2:0]  code;
        logic [3:0]  rd, rs, rt;
        logic [15:0] va, vb;
        int          exp_done, exp_nw;
        logic [3:0]  a0;
        logic [15:0] d0;
        logic [3:0]  a1;
        logic [15:0] d1;
        bit          exp_ill, exp_d0, exp_ovf;
    } vec_t;

    function automatic logic [15:0] pick_val();
        case ($urandom_range(0, 7))
            0: return 16'h0000;
            1: return 16'h0001;
            2: return 16'h7FFF;
            3: return 16'h8000;
            4: return 16'hFFFF;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t vt[$];
        int ws, dc0;

        vt.push_back('{3'd0, 4'd3, 4'd1, 4'd2, 16'd7,     16'd5,      3,     1, 4'd3,  16'd12,    4'd0,  16'd0,     0, 0, 0});
        vt.push_back('{3'd0, 4'd3, 4'd1, 4'd2, 16'h7FFF,  16'd1,      3,     1, 4'd3,  16'h8000,  4'd0,  16'd0,     0, 0, 1});
        vt.push_back('{3'd4, 4'd5, 4'd1, 4'd2, 16'h7FFF,  16'd1,      3,     1, 4'd5,  16'h0001,  4'd0,  16'd0,     0, 0, 0});
        vt.push_back('{3'd2, 4'd4, 4'd1, 4'd2, 16'd300,   16'd400,    3 + M, 2, 4'd4,  16'hD4C0,  4'd15, 16'h0001,  0, 0, 0});
        vt.push_back('{3'd3, 4'd15, 4'd1, 4'd2, 16'd17,   16'd5,      3 + M, 2, 4'd15, 16'd3,     4'd15, 16'd2,     0, 0, 0});
        vt.push_back('{3'd1, 4'd6, 4'd1, 4'd2, 16'h8000,  16'd1,      3,     1, 4'd6,  16'h7FFF,  4'd0,  16'd0,     0, 0, 1});
        vt.push_back('{3'd6, 4'd3, 4'd1, 4'd2, 16'd1,     16'd1,      1,     0, 4'd0,  16'd0,     4'd0,  16'd0,     1, 0, 1});
        vt.push_back('{3'd7, 4'd3, 4'd1, 4'd2, 16'd1,     16'd1,      1,     0, 4'd0,  16'd0,     4'd0,  16'd0,     1, 0, 1});
        vt.push_back('{3'd5, 4'd7, 4'd1, 4'd2, 16'h00F0,  16'h0F01,   3,     1, 4'd7,  16'h0FF1,  4'd0,  16'd0,     0, 0, 0});
        vt.push_back('{3'd0, 4'd1, 4'd1, 4'd1, 16'd9,     16'd9,      3,     1, 4'd1,  16'd18,    4'd0,  16'd0,     0, 0, 0});
        vt.push_back('{3'd1, 4'd2, 4'd1, 4'd2, 16'd3,     16'd10,     3,     1, 4'd2,  16'hFFF9,  4'd0,  16'd0,     0, 0, 0});
        vt.push_back('{3'd2, 4'd8, 4'd1, 4'd2, 16'hFFFD,  16'd7,      3 + M, 2, 4'd8,  16'hFFEB,  4'd15, 16'hFFFF,  0, 0, 0});
        vt.push_back('{3'd3, 4'd9, 4'd1, 4'd2, 16'hFFEF,  16'd5,      3 + M, 2, 4'd9,  16'hFFFD,  4'd15, 16'hFFFE,  0, 0, 0});
`ifdef ALU_DIV0_TRAP_EN
        vt.push_back('{3'd3, 4'd9, 4'd1, 4'd0, 16'd20,    16'd0,      2,     0, 4'd0,  16'd0,     4'd0,  16'd0,     0, 1, 0});
`else
        vt.push_back('{3'd3, 4'd9, 4'd1, 4'd0, 16'd20,    16'd0,      3 + M, 2, 4'd9,  16'hFFFF,  4'd15, 16'd20,    0, 0, 0});
`endif

        rst = 1'b1;
        ifc.op_valid = 1'b0; ifc.op_code = '0; ifc.op_rd = '0; ifc.op_rs = '0; ifc.op_rt = '0;
        repeat (3) @(negedge clk);
        chk("reset.op_ready", {31'd0, ifc.op_ready}, 32'd1);
        chk("reset.busy_done_we", {29'd0, busy, done, rf_we}, 32'd0);
        chk("reset.flags", {30'd0, status_ovf, err_illegal}, 32'd0);
        chk("reset.alu_out", {alu_a, alu_b}, 32'd0);
        chk("reset.addr_sel", {17'd0, alu_sel, rf_ra_addr, rf_rb_addr}, 32'd0);
        chk("reset.wport", {12'd0, rf_waddr, rf_wdata}, 32'd0);
        rst = 1'b0;
        ref_status = 1'b0;
        for (int i = 0; i < 16; i++) set_reg(4'(i), 16'($urandom));

        foreach (vt[i]) begin
            set_reg(vt[i].rs, vt[i].va);
            set_reg(vt[i].rt, vt[i].vb);
            run_check($sformatf("vec%0d", i), vt[i].code, vt[i].rd, vt[i].rs, vt[i].rt,
                      vt[i].exp_done, vt[i].exp_nw, vt[i].a0, vt[i].d0, vt[i].a1, vt[i].d1,
                      vt[i].exp_ill, vt[i].exp_d0, vt[i].exp_ovf);
            if (vt[i].exp_nw >= 1) ref_rf[vt[i].a0] = vt[i].d0;
            if (vt[i].exp_nw >= 2) ref_rf[vt[i].a1] = vt[i].d1;
            ref_status = vt[i].exp_ovf;
        end

        // Make status_ovf non-zero, then abandon a MUL in EXEC with reset.
        set_reg(4'd1, 16'h7FFF);
        set_reg(4'd2, 16'd1);
        ref_op(3'd0, 4'd5, 4'd1, 4'd2);
        set_reg(4'd1, 16'd300);
        set_reg(4'd2, 16'd400);
        ws = wr_cnt; dc0 = done_cnt;
        ifc.op_valid = 1'b1; ifc.op_code = OP_MUL; ifc.op_rd = 4'd4; ifc.op_rs = 4'd1; ifc.op_rt = 4'd2;
        @(negedge clk);
        ifc.op_valid = 1'b0;
        @(negedge clk);
        chk("rstmid.busy_in_exec", {31'd0, busy}, 32'd1);
        chk("rstmid.alu_sel_in_exec", {29'd0, alu_sel}, {29'd0, OP_MUL});
        rst = 1'b1;
        @(negedge clk);
        chk("rstmid.busy_after", {31'd0, busy}, 32'd0);
        chk("rstmid.ready_after", {31'd0, ifc.op_ready}, 32'd1);
        chk("rstmid.status_cleared", {31'd0, status_ovf}, 32'd0);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        chk("rstmid.no_write", wr_cnt - ws, 0);
        chk("rstmid.no_done", done_cnt - dc0, 0);
        ref_status = 1'b0;

        for (int k = 0; k < 80; k++) begin
            if ($urandom_range(0, 1) == 1) set_reg(4'($urandom_range(0, 15)), pick_val());
            if ($urandom_range(0, 1) == 1) set_reg(4'($urandom_range(0, 15)), pick_val());
            ref_op(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)),
                   4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        end

        for (int i = 0; i < 16; i++)
            chk($sformatf("final.r%0d", i), {16'd0, rf[i]}, {16'd0, ref_rf[i]});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Multi-cycle controller that sequences the 16-bit signed ALU for the CPU datapath. It accepts one operation at a time over a valid/ready handshake and reads both operands from the register file. It drives the ALU `sel`/`a`/`b` inputs, captures `r`, `R15` and `ovf`, then writes the results back: `r` to the destination register, and for MUL/DIV the upper product or remainder to R15. It sits between instruction decode and the register file / ALU pair.

## Interface
- `DW`, 16: datapath width; must match the ALU.
- `AW`, 4: register-file address width; register 15 is the R15 auxiliary register.
- `MULDIV_CYCLES`, 2: EXEC cycles for MUL/DIV (≥1); all other ops take 1.

- `clk`  in  1: single clock; every register updates on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `op_valid` in 1 / `op_ready` out 1: operation handshake; transfer occurs when both are high on a clock edge.
- `op_code`  in  3: 000 ADD, 001 SUB, 010 MUL, 011 DIV, 100 AND, 101 OR; 110 and 111 are illegal.
- `op_rd`, `op_rs`, `op_rt`  in  AW: destination and source register addresses.
- `rf_ra_addr`, `rf_rb_addr`  out  AW: register-file read addresses; the file returns data combinationally.
- `rf_ra_data`, `rf_rb_data`  in  DW: register-file read data.
- `alu_a`, `alu_b`  out  DW; `alu_sel`  out  3: ALU inputs.
- `alu_r`, `alu_r15`  in  DW; `alu_ovf`  in  1: ALU outputs.
- `rf_we`  out  1; `rf_waddr`  out  AW; `rf_wdata`  out  DW: register-file write port.
- `busy`  out  1: high in every state except IDLE.
- `done`  out  1: one-cycle pulse when an operation retires.
- `status_ovf`  out  1: captured `alu_ovf` of the last legal operation that retired.
- `err_illegal`  out  1: one-cycle pulse, coincident with `done`, when an illegal opcode retires.

## Operation
- States:
  - IDLE: `op_ready`=1. On handshake, latch `op_code`, `rd`, `rs`, `rt` and go to READ. An illegal opcode skips to DONE_ILL instead.
  - READ: drive `rf_ra_addr`=rs and `rf_rb_addr`=rt; register the read data into `a_q`/`b_q`; go to EXEC.
  - EXEC: drive `alu_a`=`a_q`, `alu_b`=`b_q`, `alu_sel`=`op_q`. Hold for 1 cycle, or `MULDIV_CYCLES` cycles for MUL/DIV. On the last cycle, capture `r_q`, `r15_q` and `ovf_q`, then go to WB.
  - WB: `rf_we`=1, `rf_waddr`=rd, `rf_wdata`=`r_q`. MUL/DIV go to WB15; all other ops pulse `done` and return to IDLE.
  - WB15: `rf_we`=1, `rf_waddr`=15, `rf_wdata`=`r15_q`. Pulse `done`; return to IDLE.
  - DONE_ILL: pulse `done` and `err_illegal`; no register write; `status_ovf` unchanged; return to IDLE.
- `status_ovf` loads `ovf_q` on `done` for every legal op. AND, OR, MUL and DIV therefore clear it.
- rd=15 with MUL/DIV: the WB15 write lands last, so R15 ends holding the high word or remainder.
- rs=rt, and rd equal to a source register, are legal. Operands are captured in READ, so a later write cannot disturb them.
- Outside their active states, `rf_we`=0 and the `alu_*`, `rf_*addr` and `rf_wdata` outputs are 0.

## Timing
- Handshake at edge T puts the block in READ during cycle T+1.
- ADD, SUB, AND, OR: EXEC at T+2, WB with `done` at T+3; 4 cycles from accept to the next `op_ready`.
- MUL/DIV: EXEC for `MULDIV_CYCLES` cycles, then WB, then WB15 with `done`. With the default of 2 the block returns to IDLE after 6 cycles.
- `op_ready` is high only in IDLE; no new operation is accepted in the same cycle as `done`.
- Reset values: all outputs 0 except `op_ready`=1; state is IDLE.
- `rst` takes priority over every transition. Reset mid-operation abandons the op with no further register write, and `done` does not pulse.

## Configuration
- `ALU_DIV0_TRAP_EN` defined:
  - A DIV with `b_q`=0 is detected in READ→EXEC and the ALU is never issued.
  - The block goes to DONE_ILL, pulses `done` together with an extra output `err_div0` (1 bit), and writes nothing.
- Not defined: no `err_div0` port; DIV by zero executes normally and the ALU results are written back as-is.

## Structure
- Shared package `alu_pkg`:
  - opcode constants: `OP_ADD`, `OP_SUB`, `OP_MUL`, `OP_DIV`, `OP_AND`, `OP_OR`;
  - the `R15_ADDR` constant;
  - the state enum;
  - an `is_muldiv()` / `is_legal()` helper.
- Single module; the ALU is external and instantiated alongside, not inside. No sub-module.

## Test plan
- R1=7, R2=5, ADD rd=3, rs=1, rt=2 → R3=12, `status_ovf`=0, `done` at accept+3, one `rf_we` pulse.
- R1=0x7FFF, R2=1, ADD → R3 written with the ALU sum; `status_ovf` equals the ALU `ovf`; a following AND clears `status_ovf`.
- R1=300, R2=400, MUL rd=4 → R4=0xD4C0, then R15=0x0001 on the next cycle; `done` on the R15 write; 6 cycles total.
- R1=17, R2=5, DIV rd=15 → R15 first written with 3, then 2; final R15=2.
- `op_code`=110 → no `rf_we`; `done` and `err_illegal` pulse 1 cycle after accept.
- `rst` asserted during MUL EXEC → no write occurs, `busy`=0 next cycle, `op_ready`=1. With `ALU_DIV0_TRAP_EN`, DIV by R0=0 gives `err_div0` with no write.
